des_out_buf: RTL and testbench
==============================

DES_OUT_BUF -- requirements
Module: des_out_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 32, FIFO entries of 64-bit blocks; power of two, minimum 32 so a full pipeline burst fits.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have port issue_i  input  1  high in the cycle the source asserts valid_i into the DES core.
REQ-005 SHALL have port accept_o  output  1  credit; the source may issue a block only while high.
REQ-006 SHALL have port data_i  input  64 [0:63]  result block from the DES core.
REQ-007 SHALL have port valid_i  input  1  data_i valid; cannot be back-pressured.
REQ-008 SHALL have port word_o  output  32 [0:31]  output word.
REQ-009 SHALL have port word_valid_o  output  1  word_o valid.
REQ-010 SHALL have port word_ready_i  input  1  sink accepts word_o.
REQ-011 SHALL have port level_o  output  clog2(DEPTH)+1  number of stored blocks.
REQ-012 SHALL have port ovf_o  output  1  sticky overflow flag (see Configuration).

Function
REQ-013 SHALL push data_i into a circular FIFO on every cycle with valid_i high and FIFO not full; read/write pointers wrap modulo DEPTH.
REQ-014 SHALL drive word_valid_o high exactly when level_o > 0; a block pushed in cycle t is visible at the output in cycle t+1.
REQ-015 SHALL serialise each block high word first: phase 0 word_o = head[0:31], phase 1 word_o = head[32:63].
REQ-016 SHALL transfer a word only when word_valid_o and word_ready_i are both high; a transfer in phase 0 sets phase 1; a transfer in phase 1 pops the head and returns to phase 0.
REQ-017 SHALL hold word_o and phase stable while word_valid_o is high and word_ready_i is low.
REQ-018 SHALL keep an in-flight counter: +1 on issue_i, -1 on valid_i, unchanged when both or neither are high.
REQ-019 SHALL drive accept_o = (level_o + in-flight) < DEPTH, decoded from registered state only.
REQ-020 SHALL accept a push when full if a phase-1 pop completes in the same cycle; level_o is then unchanged.
REQ-021 SHALL otherwise discard valid_i blocks that arrive while full, leaving FIFO contents and pointers unchanged.
REQ-022 SHALL update level_o by +1 on a push only, -1 on a pop only, and 0 on both in the same cycle.
REQ-023 SHALL treat issue_i while accept_o is low as a protocol violation; the in-flight counter still increments and saturates at DEPTH.

Reset
REQ-024 SHALL clear pointers, phase, level_o and the in-flight counter when reset_i is high at a clock edge.
REQ-025 SHALL drive word_valid_o=0, accept_o=1, level_o=0 and ovf_o=0 in the first cycle after reset; word_o is don't-care.
REQ-026 SHALL abandon a block partially read at reset, so its phase-1 word is never output.

Configuration
REQ-027 SHALL implement the overflow flag only when DES_OUT_BUF_OVF_EN is defined: ovf_o sets on any discarded push (REQ-021) and clears only on reset.
REQ-028 SHALL tie ovf_o to 0 when DES_OUT_BUF_OVF_EN is undefined, with no overflow register present.

Verification
REQ-029 SHALL cover: push 0x0123456789ABCDEF with word_ready_i=1 -> word_o 0x01234567 in cycle t+1, 0x89ABCDEF in cycle t+2, then level_o=0.
REQ-030 SHALL cover: 32 issue_i pulses with no valid_i -> accept_o low after the 32nd pulse; one valid_i with one pop -> accept_o high again.
REQ-031 SHALL cover: word_ready_i=0 for 10 cycles with the block 0xFFFF0000AAAA5555 stored -> word_o holds 0xFFFF0000 and phase stays 0.
REQ-032 SHALL cover: FIFO full and a valid_i arriving with no pop -> level_o stays 32, contents unchanged, ovf_o=1 with the macro and 0 without.
REQ-033 SHALL cover: FIFO full with a phase-1 pop coinciding with valid_i -> level_o stays 32 and the new block is output last.
REQ-034 SHALL cover: reset_i high for one cycle after the phase-0 word of a block -> next cycle word_valid_o=0, level_o=0, accept_o=1.

Source files
------------

// File: rtl/des_out_buf.sv
// Output buffer for a DES core: stores 64-bit result blocks and serialises them as 32-bit words, with credit-based issue control.
// Optional sticky overflow flag when DES_OUT_BUF_OVF_EN is defined.
module des_out_buf #(
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     issue_i,
    output logic                     accept_o,
    input  logic [0:63]              data_i,
    input  logic                     valid_i,
    output logic [0:31]              word_o,
    output logic                     word_valid_o,
    input  logic                     word_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     ovf_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } phase_t;

    phase_t          phase_q, phase_d;
    logic [0:63]     mem [DEPTH];
    logic [0:63]     head;
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [LW-1:0]   level_q, infl_q;
    logic            full, xfer, pop, push, drop;

    // Handshake decode from registered state
    always_comb begin
        full         = (level_q == LW'(DEPTH));
        word_valid_o = (level_q != '0);
        xfer         = word_valid_o && word_ready_i;
        pop          = xfer && (phase_q == PH_LO);
        push         = valid_i && (!full || pop);
        drop         = valid_i && full && !pop;
    end

    // Phase FSM: next state and word select
    always_comb begin
        phase_d = phase_q;
        head    = mem[rd_ptr_q];
        word_o  = head[0:31];
        if (phase_q == PH_LO) begin
            word_o = head[32:63];
        end
        if (xfer) begin
            phase_d = (phase_q == PH_HI) ? PH_LO : PH_HI;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q <= PH_HI;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Block storage is not reset; only pointers and level define validity
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Blocks issued to the core but not yet returned; saturates on protocol violation
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            infl_q <= '0;
        end else if (issue_i && !valid_i) begin
            if (infl_q != LW'(DEPTH)) infl_q <= infl_q + LW'(1);
        end else if (valid_i && !issue_i) begin
            if (infl_q != '0) infl_q <= infl_q - LW'(1);
        end
    end

    always_comb begin
        level_o  = level_q;
        accept_o = (({1'b0, level_q} + {1'b0, infl_q}) < (LW + 1)'(DEPTH));
    end

`ifdef DES_OUT_BUF_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_des_out_buf.sv
// Directed self-checking bench for des_out_buf (DEPTH = 32).
module tb_des_out_buf;

    localparam int unsigned DEPTH = 32;

`ifdef DES_OUT_BUF_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        issue_i;
    logic        accept_o;
    logic [0:63] data_i;
    logic        valid_i;
    logic [0:31] word_o;
    logic        word_valid_o;
    logic        word_ready_i;
    logic [5:0]  level_o;
    logic        ovf_o;

    int n_checks = 0;
    int n_errors = 0;

    des_out_buf #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .issue_i      (issue_i),
        .accept_o     (accept_o),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .level_o      (level_o),
        .ovf_o        (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        issue_i = 1'b0;
        valid_i = 1'b0;
        tick();
        reset_i = 1'b0;
    endtask

    task automatic push_blk(input logic [63:0] d);
        valid_i = 1'b1;
        data_i  = d;
        tick();
        valid_i = 1'b0;
    endtask

    initial begin
        reset_i      = 1'b1;
        issue_i      = 1'b0;
        valid_i      = 1'b0;
        data_i       = '0;
        word_ready_i = 1'b0;
        tick();
        do_reset();

        // Reset state
        check("rst_wvalid", 64'(word_valid_o), 64'd0);
        check("rst_accept", 64'(accept_o), 64'd1);
        check("rst_level",  64'(level_o), 64'd0);
        check("rst_ovf",    64'(ovf_o), 64'd0);

        // Basic serialisation, high word first
        word_ready_i = 1'b1;
        push_blk(64'h0123_4567_89AB_CDEF);
        check("ser_wvalid", 64'(word_valid_o), 64'd1);
        check("ser_hi",     64'(word_o), 64'h0123_4567);
        tick();
        check("ser_lo",     64'(word_o), 64'h89AB_CDEF);
        check("ser_lvl1",   64'(level_o), 64'd1);
        tick();
        check("ser_lvl0",   64'(level_o), 64'd0);
        check("ser_wv0",    64'(word_valid_o), 64'd0);

        // Back-pressure holds phase 0 word
        word_ready_i = 1'b0;
        push_blk(64'hFFFF_0000_AAAA_5555);
        for (int i = 0; i < 10; i++) begin
            check("hold_word", 64'(word_o), 64'hFFFF_0000);
            tick();
        end
        check("hold_level", 64'(level_o), 64'd1);
        word_ready_i = 1'b1;
        tick();
        check("hold_lo", 64'(word_o), 64'hAAAA_5555);
        tick();
        check("hold_drain", 64'(level_o), 64'd0);

        // Credit: 32 issues exhaust accept_o; one returned block popped restores it
        do_reset();
        word_ready_i = 1'b0;
        issue_i = 1'b1;
        for (int i = 0; i < 31; i++) tick();
        check("cred_31", 64'(accept_o), 64'd1);
        tick();
        issue_i = 1'b0;
        check("cred_32", 64'(accept_o), 64'd0);
        push_blk(64'h0000_0001_0000_0002);
        check("cred_push_acc", 64'(accept_o), 64'd0);
        check("cred_push_lvl", 64'(level_o), 64'd1);
        word_ready_i = 1'b1;
        tick();
        tick();
        check("cred_pop_lvl", 64'(level_o), 64'd0);
        check("cred_pop_acc", 64'(accept_o), 64'd1);
        // Simultaneous issue and valid leaves in-flight at 31
        issue_i = 1'b1;
        word_ready_i = 1'b0;
        push_blk(64'h0000_0003_0000_0004);
        issue_i = 1'b0;
        check("cred_both_acc", 64'(accept_o), 64'd0);

        // Fill to full, then a discarded push
        do_reset();
        word_ready_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            push_blk({32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i)});
        end
        check("full_level", 64'(level_o), 64'd32);
        check("full_accept", 64'(accept_o), 64'd0);
        check("full_ovf0", 64'(ovf_o), 64'd0);
        push_blk(64'hDEAD_BEEF_DEAD_BEEF);
        check("drop_level", 64'(level_o), 64'd32);
        check("drop_head", 64'(word_o), 64'h1000_0000);
        check("drop_ovf", 64'(ovf_o), 64'(OVF_EXP));

        // Full with phase-1 pop coinciding with a push
        word_ready_i = 1'b1;
        tick();
        check("fp_lo0", 64'(word_o), 64'h2000_0000);
        push_blk(64'hCAFE_0001_CAFE_0002);
        check("fp_level", 64'(level_o), 64'd32);
        word_ready_i = 1'b1;
        for (int i = 1; i < 32; i++) begin
            check("drain_hi", 64'(word_o), 64'(32'h1000_0000 + 32'(i)));
            tick();
            check("drain_lo", 64'(word_o), 64'(32'h2000_0000 + 32'(i)));
            tick();
        end
        check("last_hi", 64'(word_o), 64'hCAFE_0001);
        tick();
        check("last_lo", 64'(word_o), 64'hCAFE_0002);
        tick();
        check("drained", 64'(level_o), 64'd0);
        check("ovf_sticky", 64'(ovf_o), 64'(OVF_EXP));

        // Reset after phase-0 word abandons the block
        do_reset();
        word_ready_i = 1'b1;
        push_blk(64'h1111_2222_3333_4444);
        check("ab_hi", 64'(word_o), 64'h1111_2222);
        do_reset();
        check("ab_wvalid", 64'(word_valid_o), 64'd0);
        check("ab_level",  64'(level_o), 64'd0);
        check("ab_accept", 64'(accept_o), 64'd1);
        check("ab_ovf",    64'(ovf_o), 64'd0);
        word_ready_i = 1'b0;
        push_blk(64'h5555_6666_7777_8888);
        check("ab_next_hi", 64'(word_o), 64'h5555_6666);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
